fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage for the 4-bit processor, directly upstream of the 4096×4 program/data memory. Holds the 12-bit program counter, drives the memory's address, chip-select and read/write lines, and assembles each 8-bit instruction from two consecutive nibbles (opcode, then operand). Completed instructions go to the decoder over a valid/ready handshake. Jumps load the PC through a separate port.

## Interface
- `ADDR_W`, default 12: program counter and memory address width.
- `DATA_W`, default 4: memory nibble width; instruction = 2×`DATA_W`.
- `RESET_PC`, default 0: PC value after reset.

Ports:
- `clock` in 1: single clock; all state changes on rising edge.
- `reset` in 1: synchronous, active-high.
- `run` in 1: fetch enable; 0 = stop starting new fetches.
- `pc_load` in 1: jump request, one-cycle pulse.
- `pc_in` in ADDR_W: jump target.
- `instr_ready` in 1: decoder accepts instruction.
- `instr_valid` out 1: opcode/operand/instr_pc hold a complete instruction.
- `opcode` out DATA_W: first nibble (address PC).
- `operand` out DATA_W: second nibble (address PC+1).
- `instr_pc` out ADDR_W: address of the opcode nibble.
- `pc` out ADDR_W: current program counter.
- `mem_address` out ADDR_W: memory address.
- `mem_chips` out 1: memory chip select.
- `mem_enableRW` out 1: memory read/write select; fetch only reads, so it is tied to 0.
- `mem_data` in DATA_W: memory data bus, read side.

## Operation
- Memory read protocol, two cycles per nibble. SEL cycle: `mem_chips`=1, `mem_enableRW`=0, address stable; memory latches the word. CAP cycle: `mem_chips`=0, `mem_enableRW`=0, same address; memory drives `mem_data`; the block samples it at the end of CAP.
- FSM states: IDLE, HI_SEL, HI_CAP, LO_SEL, LO_CAP, VALID.
  - IDLE→HI_SEL when `run`=1; otherwise stay in IDLE.
  - HI_SEL→HI_CAP.
  - HI_CAP→LO_SEL: `opcode`←`mem_data`, `instr_pc`←`pc`, `pc`←`pc`+1.
  - LO_SEL→LO_CAP.
  - LO_CAP→VALID: `operand`←`mem_data`, `pc`←`pc`+1.
  - In VALID, when `instr_ready`=1: go to HI_SEL if `run`=1, else IDLE. When `instr_ready`=0: stay in VALID.
- `instr_valid`=1 only in VALID. `opcode`, `operand` and `instr_pc` are stable while `instr_valid`=1.
- `mem_address`=`pc` in every state. `mem_chips`=1 only in HI_SEL and LO_SEL.
- PC arithmetic is modulo 2^ADDR_W: 4095+1 = 0. An instruction whose opcode is at 4095 takes its operand from address 0.
- `run`=0 mid-fetch: the in-flight instruction completes to VALID. Only the next HI_SEL is blocked.
- `pc_load`=1 has top priority in every state except reset.
  - `pc`←`pc_in`, the in-flight fetch is aborted, and the next state is HI_SEL (IDLE if `run`=0).
  - `instr_valid` is 0 the next cycle.
  - If `pc_load` coincides with `instr_valid`&`instr_ready`, the transfer counts as completed and the next fetch starts at `pc_in`.
- `reset`=1 (including mid-fetch) on the next edge:
  - state←IDLE, `pc`←`RESET_PC`;
  - `opcode`, `operand`, `instr_pc`←0;
  - `instr_valid`=0, `mem_chips`=0, `mem_enableRW`=0.
  - Reset overrides `pc_load`.

## Timing
- All outputs are registered or decoded from the state register only; no combinational path from inputs to outputs.
- Latency: `run` high in cycle 0 (IDLE) → HI_SEL in cycle 1 → `instr_valid` high in cycle 5.
- Throughput with `instr_ready` held 1: one instruction per 5 cycles. That is 4 fetch cycles plus 1 VALID cycle; fetches do not overlap the handshake.
- Jump: `pc_load` in cycle n → HI_SEL at `pc_in` in cycle n+1 → `instr_valid` in cycle n+5.
- `mem_data` is sampled only in HI_CAP and LO_CAP. Its value in other cycles is don't-care (it may be Z).

## Structure
- Shared package `cpu_pkg` holds:
  - `ADDR_W`, `DATA_W` and `RESET_PC` defaults;
  - the fetch state encoding (3-bit: IDLE=0 … VALID=5), shared with the debug/trace logic.
- One natural sub-module, `program_counter`: ADDR_W register with synchronous reset, load, increment-with-wrap, and load priority over increment.
- FSM and instruction register stay in `fetch_unit`.

## Test plan
- Reset, then preload mem[0]=4'hA and mem[1]=4'h3, `run`=1 and `instr_ready`=1. Required: `instr_valid` in cycle 5, `opcode`=A, `operand`=3, `instr_pc`=0, `pc`=2, and `mem_chips` high only in cycles 1 and 3.
- `instr_ready`=0 for 4 cycles after valid. Required: outputs hold unchanged, no `mem_chips` pulses, and the next fetch starts the cycle after `instr_ready` rises.
- `pc_load`=1 with `pc_in`=12'h100 during HI_CAP, mem[100]=5 and mem[101]=7. Required: the aborted instruction is never presented, and valid arrives 4 cycles after HI_SEL with 5/7 and `instr_pc`=12'h100.
- Wrap-around: `pc_in`=12'hFFF, mem[FFF]=2 and mem[0]=9. Required: `opcode`=2, `operand`=9, `instr_pc`=FFF, `pc`=1.
- `run` dropped during LO_SEL. Required: the instruction completes to VALID, then the FSM goes to IDLE after the handshake and `mem_chips` stays 0.
- `reset` asserted during LO_CAP. Required: next cycle is IDLE, `pc`=0, and all outputs are 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the 4-bit processor.
// Holds width defaults and the fetch state encoding used by debug/trace.
package cpu_pkg;

    localparam int DEF_ADDR_W   = 12;
    localparam int DEF_DATA_W   = 4;
    localparam int DEF_RESET_PC = 0;

    typedef enum logic [2:0] {
        FS_IDLE   = 3'd0,
        FS_HI_SEL = 3'd1,
        FS_HI_CAP = 3'd2,
        FS_LO_SEL = 3'd3,
        FS_LO_CAP = 3'd4,
        FS_VALID  = 3'd5
    } fetch_state_e;

endpackage

// File: rtl/program_counter.sv
// Program counter register: load beats increment, increment wraps.
// Synchronous active-high reset to RESET_PC.
module program_counter #(
    parameter int              ADDR_W   = 12,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic              incr,
    input  logic [ADDR_W-1:0] load_val,
    output logic [ADDR_W-1:0] pc
);

    localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    // Next PC: jump target first, then wrapping increment, else hold
    always_comb begin
        pc_d = pc_q;
        if (load) begin
            pc_d = load_val;
        end else if (incr) begin
            pc_d = pc_q + ONE;
        end
    end

    // PC register
    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: two-cycle nibble reads, opcode then operand,
// handed to the decoder over valid/ready. Jumps abort in-flight fetches.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = DEF_ADDR_W,
    parameter int                DATA_W   = DEF_DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              run,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              instr_ready,
    output logic              instr_valid,
    output logic [DATA_W-1:0] opcode,
    output logic [DATA_W-1:0] operand,
    output logic [ADDR_W-1:0] instr_pc,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_chips,
    output logic              mem_enableRW,
    input  logic [DATA_W-1:0] mem_data
);

    fetch_state_e      state_q, state_d;
    logic [DATA_W-1:0] opcode_q, opcode_d;
    logic [DATA_W-1:0] operand_q, operand_d;
    logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
    logic              pc_incr;

    program_counter #(
        .ADDR_W  (ADDR_W),
        .RESET_PC(RESET_PC)
    ) u_pc (
        .clock   (clock),
        .reset   (reset),
        .load    (pc_load),
        .incr    (pc_incr),
        .load_val(pc_in),
        .pc      (pc)
    );

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= FS_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a jump restarts the fetch from HI_SEL (or parks in IDLE)
    always_comb begin
        state_d = state_q;
        if (pc_load) begin
            state_d = run ? FS_HI_SEL : FS_IDLE;
        end else begin
            unique case (state_q)
                FS_IDLE:   state_d = run ? FS_HI_SEL : FS_IDLE;
                FS_HI_SEL: state_d = FS_HI_CAP;
                FS_HI_CAP: state_d = FS_LO_SEL;
                FS_LO_SEL: state_d = FS_LO_CAP;
                FS_LO_CAP: state_d = FS_VALID;
                FS_VALID: begin
                    if (instr_ready) begin
                        state_d = run ? FS_HI_SEL : FS_IDLE;
                    end
                end
                default:   state_d = FS_IDLE;
            endcase
        end
    end

    // Outputs decoded from the state register only
    always_comb begin
        instr_valid  = (state_q == FS_VALID);
        mem_chips    = (state_q == FS_HI_SEL) || (state_q == FS_LO_SEL);
        mem_enableRW = 1'b0;
    end

    // Capture nibbles at the end of each CAP cycle unless a jump aborts
    always_comb begin
        opcode_d   = opcode_q;
        operand_d  = operand_q;
        instr_pc_d = instr_pc_q;
        pc_incr    = 1'b0;
        if (!pc_load) begin
            if (state_q == FS_HI_CAP) begin
                opcode_d   = mem_data;
                instr_pc_d = pc;
                pc_incr    = 1'b1;
            end else if (state_q == FS_LO_CAP) begin
                operand_d  = mem_data;
                pc_incr    = 1'b1;
            end
        end
    end

    // Instruction register
    always_ff @(posedge clock) begin
        if (reset) begin
            opcode_q   <= '0;
            operand_q  <= '0;
            instr_pc_q <= '0;
        end else begin
            opcode_q   <= opcode_d;
            operand_q  <= operand_d;
            instr_pc_q <= instr_pc_d;
        end
    end

    assign opcode      = opcode_q;
    assign operand     = operand_q;
    assign instr_pc    = instr_pc_q;
    assign mem_address = pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit with a 4096x4 SEL/CAP memory model.
// Directed sequences, a jump table and a randomized transaction model.
module tb_fetch_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        run = 1'b0;
    logic        pc_load = 1'b0;
    logic [11:0] pc_in = '0;
    logic        instr_ready = 1'b0;
    logic        instr_valid;
    logic [3:0]  opcode;
    logic [3:0]  operand;
    logic [11:0] instr_pc;
    logic [11:0] pc;
    logic [11:0] mem_address;
    logic        mem_chips;
    logic        mem_enableRW;
    logic [3:0]  mem_data;

    logic [3:0]  mem [4096];
    logic [3:0]  mem_lat = '0;

    int n_cmp = 0;
    int n_bad = 0;

    fetch_unit dut (
        .clock       (clock),
        .reset       (reset),
        .run         (run),
        .pc_load     (pc_load),
        .pc_in       (pc_in),
        .instr_ready (instr_ready),
        .instr_valid (instr_valid),
        .opcode      (opcode),
        .operand     (operand),
        .instr_pc    (instr_pc),
        .pc          (pc),
        .mem_address (mem_address),
        .mem_chips   (mem_chips),
        .mem_enableRW(mem_enableRW),
        .mem_data    (mem_data)
    );

    always #5 clock = ~clock;

    // Memory latches the addressed word in SEL and drives it in CAP
    always @(posedge clock) begin
        if (mem_chips) mem_lat <= mem[mem_address];
    end
    assign mem_data = mem_lat;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [11:0] addr;
        logic [3:0]  op;
        logic [3:0]  opd;
        logic [11:0] exp_pc;
    } vec_t;

    vec_t tbl [5];

    initial begin
        logic [11:0] a1;
        logic [3:0]  snap_op, snap_opd;
        logic [11:0] snap_ipc, snap_pc;
        int          lat;
        logic [11:0] next_start;
        int          hs;

        for (int i = 0; i < 4096; i++) mem[i] = '0;

        // ---- reset state ----
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_chips", 32'(mem_chips), 32'd0);
        chk("rst_rw", 32'(mem_enableRW), 32'd0);
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_fields", {20'd0, opcode, operand, 4'd0}, 32'd0);

        // ---- first fetch: latency and select pattern ----
        mem[0] = 4'hA;
        mem[1] = 4'h3;
        mem[12'h100] = 4'h5;
        mem[12'h101] = 4'h7;
        run = 1'b1;
        instr_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            step();
            chk($sformatf("f1_chips_c%0d", k), 32'(mem_chips),
                32'(k == 1 || k == 3));
            chk($sformatf("f1_valid_c%0d", k), 32'(instr_valid),
                32'(k == 5));
        end
        chk("f1_opcode", 32'(opcode), 32'hA);
        chk("f1_operand", 32'(operand), 32'h3);
        chk("f1_instr_pc", 32'(instr_pc), 32'h0);
        chk("f1_pc", 32'(pc), 32'h2);

        // ---- stall: outputs hold, no selects ----
        snap_op = opcode;
        snap_opd = operand;
        snap_ipc = instr_pc;
        snap_pc = pc;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("stall_valid", 32'(instr_valid), 32'd1);
            chk("stall_chips", 32'(mem_chips), 32'd0);
            chk("stall_hold", {8'd0, snap_op, snap_opd, snap_ipc, snap_pc} ^
                {8'd0, opcode, operand, instr_pc, pc}, 32'd0);
        end
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        chk("stall_restart_chips", 32'(mem_chips), 32'd1);
        chk("stall_restart_valid", 32'(instr_valid), 32'd0);
        chk("stall_restart_addr", 32'(mem_address), 32'h2);

        // ---- jump during HI_CAP ----
        step();
        pc_load = 1'b1;
        pc_in = 12'h100;
        step();
        pc_load = 1'b0;
        instr_ready = 1'b1;
        chk("jmp_hisel_chips", 32'(mem_chips), 32'd1);
        chk("jmp_hisel_addr", 32'(mem_address), 32'h100);
        chk("jmp_hisel_valid", 32'(instr_valid), 32'd0);
        for (int k = 1; k <= 4; k++) begin
            step();
            chk($sformatf("jmp_valid_c%0d", k), 32'(instr_valid),
                32'(k == 4));
        end
        chk("jmp_opcode", 32'(opcode), 32'h5);
        chk("jmp_operand", 32'(operand), 32'h7);
        chk("jmp_instr_pc", 32'(instr_pc), 32'h100);

        // ---- jump table, includes wrap at 0xFFF ----
        tbl[0] = '{12'h040, 4'h1, 4'hE, 12'h042};
        tbl[1] = '{12'hFFF, 4'h2, 4'h9, 12'h001};
        tbl[2] = '{12'h7FE, 4'hC, 4'h4, 12'h800};
        tbl[3] = '{12'h123, 4'hF, 4'h0, 12'h125};
        tbl[4] = '{12'hFFE, 4'h6, 4'hB, 12'h000};
        for (int i = 0; i < 5; i++) begin
            a1 = tbl[i].addr + 12'd1;
            mem[tbl[i].addr] = tbl[i].op;
            mem[a1] = tbl[i].opd;
            run = 1'b1;
            instr_ready = 1'b1;
            pc_load = 1'b1;
            pc_in = tbl[i].addr;
            step();
            pc_load = 1'b0;
            lat = 0;
            while (!instr_valid && lat < 10) begin
                step();
                lat++;
            end
            chk($sformatf("tbl%0d_latency", i), 32'(lat), 32'd4);
            chk($sformatf("tbl%0d_opcode", i), 32'(opcode), 32'(tbl[i].op));
            chk($sformatf("tbl%0d_operand", i), 32'(operand),
                32'(tbl[i].opd));
            chk($sformatf("tbl%0d_instr_pc", i), 32'(instr_pc),
                32'(tbl[i].addr));
            chk($sformatf("tbl%0d_pc", i), 32'(pc), 32'(tbl[i].exp_pc));
        end

        // ---- run dropped during LO_SEL ----
        mem[12'h200] = 4'h8;
        mem[12'h201] = 4'h1;
        run = 1'b1;
        instr_ready = 1'b1;
        pc_load = 1'b1;
        pc_in = 12'h200;
        step();
        pc_load = 1'b0;
        step();
        step();
        chk("stop_in_losel", 32'(mem_chips), 32'd1);
        run = 1'b0;
        step();
        step();
        chk("stop_valid", 32'(instr_valid), 32'd1);
        chk("stop_fields", {24'd0, opcode, operand}, 32'h81);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("stop_idle_valid", 32'(instr_valid), 32'd0);
            chk("stop_idle_chips", 32'(mem_chips), 32'd0);
        end

        // ---- reset during LO_CAP ----
        run = 1'b1;
        pc_load = 1'b1;
        pc_in = 12'h300;
        step();
        pc_load = 1'b0;
        step();
        step();
        step();
        reset = 1'b1;
        pc_load = 1'b1;
        pc_in = 12'h555;
        step();
        reset = 1'b0;
        pc_load = 1'b0;
        run = 1'b0;
        chk("rst2_pc", 32'(pc), 32'd0);
        chk("rst2_addr", 32'(mem_address), 32'd0);
        chk("rst2_outs", {instr_valid, mem_chips, mem_enableRW},
            32'd0);
        chk("rst2_fields", {8'd0, opcode, operand, instr_pc}, 32'd0);
        step();
        chk("rst2_idle_chips", 32'(mem_chips), 32'd0);

        // ---- randomized traffic vs transaction-level model ----
        for (int i = 0; i < 4096; i++) mem[i] = 4'($urandom);
        reset = 1'b1;
        step();
        reset = 1'b0;
        next_start = 12'd0;
        hs = 0;
        for (int c = 0; c < 4000; c++) begin
            run = ($urandom_range(0, 7) != 0);
            instr_ready = ($urandom_range(0, 2) != 0);
            pc_load = ($urandom_range(0, 24) == 0);
            pc_in = 12'($urandom);
            if (mem_enableRW !== 1'b0) chk("rnd_rw", 32'(mem_enableRW), 32'd0);
            if (instr_valid && instr_ready) begin
                a1 = next_start + 12'd1;
                chk("rnd_instr_pc", 32'(instr_pc), 32'(next_start));
                chk("rnd_opcode", 32'(opcode), 32'(mem[next_start]));
                chk("rnd_operand", 32'(operand), 32'(mem[a1]));
                chk("rnd_pc", 32'(pc), 32'(next_start + 12'd2));
                next_start = next_start + 12'd2;
                hs++;
            end
            if (pc_load) next_start = pc_in;
            step();
        end
        pc_load = 1'b0;
        chk("rnd_handshakes_min", 32'(hs >= 100), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
